// File: rtl/shiftreg_pkg.sv
// Shared types and helpers for the 74HC595-style serial transmitter.
package shiftreg_pkg;

  // Transmitter frame phases.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  // Counter width for a counter that runs 0..n-1; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Cycles with data_ready low for one frame: WIDTH low/high bit periods
  // followed by one latch half-period.
  function automatic int frame_len(input int width, input int clk_div);
    return 2 * width * clk_div + clk_div;
  endfunction

endpackage

// File: rtl/shiftreg_tx_phase.sv
// Half-period counter: counts 0..CLK_DIV-1 while enabled, wraps to 0 after
// the terminal count, and holds 0 while cleared.
module shiftreg_tx_phase
  import shiftreg_pkg::*;
#(
  parameter int CLK_DIV = 4,
  localparam int PW = cnt_width(CLK_DIV)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic          terminal,
  output logic [PW-1:0] count
);

  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  // Terminal flags the last cycle of the current half-period.
  assign terminal = (count == LAST);

  // Count register; wraps on terminal so it never runs past CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= terminal ? '0 : count + PW'(1);
    end
  end

endmodule

// File: rtl/shiftreg_tx.sv
// Serial transmitter for a 74HC595 chain: accepts a parallel word, shifts it
// out on a divided serial clock, then pulses the storage latch.
//
// Handshake: a word is taken on any rising clk edge where data_valid and
// data_ready are both 1. data_ready is high only in IDLE; the host must hold
// data_valid (and data_in) until it sees data_ready. Valid while busy is
// ignored and data_in is not looked at again until the next IDLE.
//
// Every output is a flop loaded from next-state decode, so outputs change
// only on clk edges and shiftreg_clk cannot glitch. state_q is the FSM state
// for anyone probing the design.
module shiftreg_tx
  import shiftreg_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             busy,
  output logic             done,
  output logic             shiftreg_clk,
  output logic             shiftreg_data,
  output logic             shiftreg_latch
);

  localparam int PW = cnt_width(CLK_DIV);
  localparam int BW = cnt_width(WIDTH);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] buf_q;
  logic [WIDTH-1:0] buf_d;
  logic [BW-1:0]    bit_cnt_q;
  logic [BW-1:0]    bit_cnt_d;
  logic             phase_clr;
  logic             phase_en;
  logic             phase_term;
  logic [PW-1:0]    phase_cnt;
  logic [PW-1:0]    phase_cnt_d;
  logic             cur_bit;
  logic             in_bit;

  shiftreg_tx_phase #(
    .CLK_DIV (CLK_DIV)
  ) u_phase (
    .clk      (clk),
    .reset    (reset),
    .clr      (phase_clr),
    .en       (phase_en),
    .terminal (phase_term),
    .count    (phase_cnt)
  );

  // Next-state, buffer/bit-counter updates and phase counter control.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    bit_cnt_d = bit_cnt_q;
    phase_clr = 1'b0;
    phase_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_clr = 1'b1;
        if (data_valid) begin
          buf_d     = data_in;
          bit_cnt_d = BIT_LAST;
          state_d   = ST_LOW;
        end
      end
      ST_LOW: begin
        phase_en = 1'b1;
        if (phase_term) begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        phase_en = 1'b1;
        if (phase_term) begin
          if (bit_cnt_q != '0) begin
            buf_d     = MSB_FIRST ? (buf_q << 1) : (buf_q >> 1);
            bit_cnt_d = bit_cnt_q - BW'(1);
            state_d   = ST_LOW;
          end else begin
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        phase_en = 1'b1;
        if (phase_term) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Value the phase counter will hold next cycle (it wraps on every
  // state change), used to place done on the final latch cycle.
  always_comb begin
    phase_cnt_d = '0;
    if (phase_en && !phase_term) begin
      phase_cnt_d = phase_cnt + PW'(1);
    end
  end

  // Bit presented on SER next cycle, taken from the updated buffer so data
  // changes together with the falling edge of shiftreg_clk.
  always_comb begin
    cur_bit = MSB_FIRST ? buf_d[WIDTH-1] : buf_d[0];
    in_bit  = (state_d == ST_LOW) || (state_d == ST_HIGH);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs; reset aborts any frame with no latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q          <= '0;
      bit_cnt_q      <= '0;
      data_ready     <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      shiftreg_clk   <= 1'b0;
      shiftreg_data  <= 1'b0;
      shiftreg_latch <= 1'b0;
    end else begin
      buf_q          <= buf_d;
      bit_cnt_q      <= bit_cnt_d;
      data_ready     <= (state_d == ST_IDLE);
      busy           <= (state_d != ST_IDLE);
      done           <= (state_d == ST_LATCH) && (phase_cnt_d == PHASE_LAST);
      shiftreg_clk   <= (state_d == ST_HIGH);
      shiftreg_data  <= in_bit && cur_bit;
      shiftreg_latch <= (state_d == ST_LATCH);
    end
  end

endmodule

// File: doc/shiftreg_tx.md
Name: shiftreg_tx

Overview:
Serial transmitter for a 74HC595-style serial-in/parallel-out shift register chain driving board LEDs and outputs. It is the write-side counterpart of the shift-register input controller, which reads a parallel-load chain. A host-side master (CPU PIO bridge) presents a parallel word with a valid/ready handshake. The block shifts the word out on a divided serial clock, then pulses the storage-register latch.

Parameters:
WIDTH, 16, bits per frame (number of chained register bits); must be >= 1.
CLK_DIV, 4, system cycles per serial-clock half-period; must be >= 1.
MSB_FIRST, 1, 1 = bit WIDTH-1 is shifted first; 0 = bit 0 is shifted first.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  WIDTH  parallel word to transmit.
data_valid  input  1  host asserts while data_in is valid.
data_ready  output  1  block can accept a word; a transfer occurs on data_valid && data_ready.
busy  output  1  frame in progress; equals !data_ready.
done  output  1  one-cycle pulse on the last cycle of the latch phase.
shiftreg_clk  output  1  serial shift clock (SRCLK).
shiftreg_data  output  1  serial data (SER).
shiftreg_latch  output  1  storage latch (RCLK); active-high pulse.

Behaviour:
- Reset state, applied on the clock edge where reset=1:
  - state=IDLE, data_ready=1, busy=0, done=0.
  - shiftreg_clk=0, shiftreg_data=0, shiftreg_latch=0.
  - All counters=0 and the shift buffer=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- States: IDLE, LOW, HIGH, LATCH.
- IDLE:
  - data_ready=1.
  - On data_valid=1, capture data_in into the shift buffer, load bit_cnt=WIDTH-1, phase_cnt=0, and go to LOW.
  - data_in is not sampled again during the frame.
- LOW (CLK_DIV cycles):
  - shiftreg_clk=0; shiftreg_data = current bit (MSB or LSB of the buffer per MSB_FIRST).
  - Data is stable for the full low half-period before the rising edge (setup time).
  - When phase_cnt reaches CLK_DIV-1, go to HIGH.
- HIGH (CLK_DIV cycles):
  - shiftreg_clk=1; shiftreg_data holds the same bit (hold time).
  - At the end of the phase:
    - if bit_cnt != 0: shift the buffer by one, decrement bit_cnt, go to LOW.
    - else: go to LATCH.
- LATCH (CLK_DIV cycles):
  - shiftreg_latch=1, shiftreg_clk=0, shiftreg_data=0.
  - done=1 on the final latch cycle.
  - Then go to IDLE, where data_ready=1 on the next cycle.
- Frame length: exactly 2*WIDTH*CLK_DIV + CLK_DIV cycles with data_ready=0.
  - Defaults: 132 cycles.
  - The next accept can happen on the first IDLE cycle.
- Back-to-back frames:
  - The minimum accept-to-accept spacing is frame length + 1 cycles.
  - There is no gap requirement beyond the single IDLE cycle.
- data_valid while busy is ignored. No queueing; the host must hold data_valid until it sees data_ready.
- Exactly WIDTH rising edges of shiftreg_clk per frame.
  - No rising edge of shiftreg_clk while shiftreg_latch=1.
  - No glitches on shiftreg_clk.
- Counter widths:
  - phase_cnt uses $clog2(CLK_DIV) bits, minimum 1.
  - bit_cnt uses $clog2(WIDTH) bits, minimum 1.
  - Counters never wrap past their terminal values.
- Reset mid-frame:
  - Abort immediately and return to the reset state.
  - No latch pulse is issued, so the external storage register keeps its previous value.
  - The partially shifted data is discarded.
- Simultaneous reset and data_valid: reset wins and nothing is captured.

Decomposition:
- Package shiftreg_pkg holds:
  - the state enum (IDLE, LOW, HIGH, LATCH);
  - localparam helpers for counter widths;
  - the frame-length constant function, shared with the bench.
- One natural sub-module: shiftreg_tx_phase, a half-period counter.
  - Parameter CLK_DIV; inputs clr and en; output terminal pulse.
  - Reused by the input-side controller.
- The state machine and shift buffer stay in shiftreg_tx.

Test Plan:
1. Reset, then idle 10 cycles -> data_ready=1, all shiftreg_* outputs=0, done=0 throughout.
2. Defaults, send data_in=16'hA5C3 with one-cycle valid -> data_ready low for 132 cycles; 16 shiftreg_clk rises; the bench model's shift register samples 16'hA5C3; one latch pulse of 4 cycles; done on its last cycle.
3. MSB_FIRST=0, WIDTH=8, CLK_DIV=1, data 8'h01 -> first sampled bit 1, then seven 0s; frame length 17 cycles.
4. Back-to-back: hold valid high with 16'hFFFF then 16'h0000 -> second accept exactly 1 cycle after the first done; the latched outputs read FFFF then 0000.
5. Change data_in and toggle data_valid mid-frame -> the transmitted word equals the originally captured value; no second accept until IDLE.
6. Assert reset during bit 7 of a frame -> next cycle all outputs are 0 and data_ready=1; no latch pulse occurs; the previous latched value is retained in the model.
